bias_activation: RTL and testbench

//  Post-matmul stage: adds a per-column bias vector to the d1 x d3 product from the matmul

---
 rtl/nn_pkg.sv | 19 +
 rtl/fx_sat_add.sv | 26 ++
 rtl/bias_activation.sv | 116 +++++++++++
 tb/tb_bias_activation.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared fixed-point word type, saturation limits and stage FSM states for the NN datapath.
package nn_pkg;

    localparam int FX_WIDTH = 32;
    localparam int FX_FRAC  = 15;

    typedef logic signed [FX_WIDTH-1:0] fx_word_t;

    localparam fx_word_t FX_MAX = {1'b0, {(FX_WIDTH-1){1'b1}}};
    localparam fx_word_t FX_MIN = {1'b1, {(FX_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/fx_sat_add.sv
// Combinational signed two's-complement adder that clamps to the representable range
// instead of wrapping; shared by the accumulating stages.
module fx_sat_add #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0] wide;

    assign wide = {a[WIDTH-1], a} + {b[WIDTH-1], b};

    // The two top bits of the extended sum disagree only on overflow; the extra bit is the true sign.
    always_comb begin
        sum = wide[WIDTH-1:0];
        if (wide[WIDTH] != wide[WIDTH-1]) begin
            sum = wide[WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/bias_activation.sv
// Adds a per-column bias to the matmul product and applies ReLU, one element per clock.
// Define BIAS_ACTIVATION_LEAKY_EN to replace ReLU with leaky ReLU (arithmetic shift by LEAK_SHIFT).
module bias_activation
    import nn_pkg::*;
#(
    parameter int FRACTION_WIDTH = 15,
    parameter int BIT_WIDTH      = 32,
    parameter int d1             = 5,
    parameter int d3             = 5,
    parameter int LEAK_SHIFT     = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [d1-1:0][d3-1:0][BIT_WIDTH-1:0]   mat_in,
    input  logic [d3-1:0][BIT_WIDTH-1:0]           bias,
    output logic [d1-1:0][d3-1:0][BIT_WIDTH-1:0]   result,
    output logic                                   busy,
    output logic                                   done
);

    localparam int ROW_W = (d1 > 1) ? $clog2(d1) : 1;
    localparam int COL_W = (d3 > 1) ? $clog2(d3) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(d1 - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(d3 - 1);

    if (FRACTION_WIDTH >= BIT_WIDTH || LEAK_SHIFT >= BIT_WIDTH || d1 < 1 || d3 < 1) begin : g_param_check
        $error("bias_activation: invalid parameter combination");
    end

    state_t state;
    state_t state_next;

    logic                                 start_q;
    logic                                 start_edge;
    logic [ROW_W-1:0]                     row;
    logic [COL_W-1:0]                     col;
    logic                                 last_elem;
    logic [d1-1:0][d3-1:0][BIT_WIDTH-1:0] snap_mat;
    logic [d3-1:0][BIT_WIDTH-1:0]         snap_bias;
    logic [BIT_WIDTH-1:0]                 sat_sum;
    logic [BIT_WIDTH-1:0]                 act_value;

    assign start_edge = start & ~start_q;
    assign last_elem  = (row == ROW_LAST) && (col == COL_LAST);
    assign busy       = (state == LOAD) || (state == RUN);
    assign done       = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_edge) state_next = LOAD;
            LOAD:    state_next = RUN;
            RUN:     if (last_elem) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    fx_sat_add #(
        .WIDTH (BIT_WIDTH)
    ) u_sat_add (
        .a   (snap_mat[row][col]),
        .b   (snap_bias[col]),
        .sum (sat_sum)
    );

    // Activation acts on the already-saturated sum, so the leaky path can never overflow.
    always_comb begin
        act_value = sat_sum;
        if (sat_sum[BIT_WIDTH-1]) begin
`ifdef BIAS_ACTIVATION_LEAKY_EN
            act_value = BIT_WIDTH'($signed(sat_sum) >>> LEAK_SHIFT);
`else
            act_value = '0;
`endif
        end
    end

    // Inputs are snapshotted in LOAD so upstream may change them once the pass has begun.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q   <= 1'b0;
            row       <= '0;
            col       <= '0;
            snap_mat  <= '0;
            snap_bias <= '0;
            result    <= '0;
        end else begin
            start_q <= start;
            if (state == LOAD) begin
                snap_mat  <= mat_in;
                snap_bias <= bias;
                row       <= '0;
                col       <= '0;
            end else if (state == RUN) begin
                result[row][col] <= act_value;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bias_activation.sv
// Randomised self-checking bench for bias_activation against an integer-arithmetic reference.
// Honours BIAS_ACTIVATION_LEAKY_EN the same way as the design.
module tb_bias_activation;

    localparam int BW = 32;
    localparam int D1 = 2;
    localparam int D3 = 2;
    localparam int PASS_LAT = 2 + D1 * D3;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    typedef logic [D1-1:0][D3-1:0][BW-1:0] mat_t;
    typedef logic [D3-1:0][BW-1:0]         vec_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    mat_t mat_in;
    vec_t bias;
    mat_t result;
    logic busy;
    logic done;

    int checks = 0;
    int errors = 0;

    bias_activation #(
        .FRACTION_WIDTH (15),
        .BIT_WIDTH      (BW),
        .d1             (D1),
        .d3             (D3),
        .LEAK_SHIFT     (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mat_in (mat_in),
        .bias   (bias),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Reference: exact integer sum, clamp, then activation (floor divide by 8 for leaky).
    function automatic logic [BW-1:0] ref_elem(logic [BW-1:0] a, logic [BW-1:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (s > MAXV) s = MAXV;
        else if (s < MINV) s = MINV;
        if (s < 0) begin
`ifdef BIAS_ACTIVATION_LEAKY_EN
            s = (s - 7) / 8;
`else
            s = 0;
`endif
        end
        return s[BW-1:0];
    endfunction

    function automatic mat_t ref_matrix(mat_t m, vec_t b);
        mat_t r;
        for (int i = 0; i < D1; i++)
            for (int j = 0; j < D3; j++)
                r[i][j] = ref_elem(m[i][j], b[j]);
        return r;
    endfunction

    function automatic logic [BW-1:0] rand_word();
        logic [BW-1:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) != 0) w = BW'($signed(w) >>> 12);
        return w;
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int i = 0; i < D1; i++)
            for (int j = 0; j < D3; j++)
                m[i][j] = rand_word();
        return m;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int j = 0; j < D3; j++) v[j] = rand_word();
        return v;
    endfunction

    // Raises start, waits (bounded) for done, drops start and steps one more cycle.
    task automatic run_pass(input bit scramble, output int lat);
        lat = -1;
        start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (scramble && i == 2) begin
                mat_in = rand_mat();
                bias   = rand_vec();
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        mat_in = '0;
        bias = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        for (int i = 0; i < D1; i++)
            for (int j = 0; j < D3; j++) begin
                checks++;
                if (result[i][j] !== '0) begin
                    errors++;
                    $display("[TB] FAIL reset_result[%0d][%0d]: got %h want 0", i, j, result[i][j]);
                end
            end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_relu_basic();
        mat_t exp_m;
        int lat;
        logic [BW-1:0] exp11;
        mat_in[0][0] = 32'h0000C000;
        mat_in[0][1] = 32'h00012345;
        mat_in[1][0] = 32'h00000000;
        mat_in[1][1] = 32'hFFFF0000;
        bias[0] = 32'hFFFFC000;
        bias[1] = 32'h00004000;
`ifdef BIAS_ACTIVATION_LEAKY_EN
        exp11 = 32'hFFFFE800;
`else
        exp11 = 32'h00000000;
`endif
        exp_m = ref_matrix(mat_in, bias);
        run_pass(1'b0, lat);
        checks++;
        if (lat !== PASS_LAT) begin errors++; $display("[TB] FAIL basic_latency: got %0d want %0d", lat, PASS_LAT); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_width: got %b want 0", done); end
        checks++;
        if (result[0][0] !== 32'h00008000) begin errors++; $display("[TB] FAIL basic_r00: got %h want 00008000", result[0][0]); end
        checks++;
        if (result[1][1] !== exp11) begin errors++; $display("[TB] FAIL basic_r11: got %h want %h", result[1][1], exp11); end
        for (int i = 0; i < D1; i++)
            for (int j = 0; j < D3; j++) begin
                checks++;
                if (result[i][j] !== exp_m[i][j]) begin
                    errors++;
                    $display("[TB] FAIL basic_model[%0d][%0d]: got %h want %h", i, j, result[i][j], exp_m[i][j]);
                end
            end
    endtask

    task automatic test_saturation();
        mat_t exp_m;
        int lat;
        mat_in[0][0] = 32'h80000000;
        mat_in[0][1] = 32'h7FFFFFFF;
        mat_in[1][0] = 32'h80000000;
        mat_in[1][1] = 32'h7FFFFFFF;
        bias[0] = 32'h80000000;
        bias[1] = 32'h00000001;
        exp_m = ref_matrix(mat_in, bias);
        run_pass(1'b0, lat);
        checks++;
        if (lat !== PASS_LAT) begin errors++; $display("[TB] FAIL sat_latency: got %0d want %0d", lat, PASS_LAT); end
        checks++;
        if (result[0][1] !== 32'h7FFFFFFF) begin errors++; $display("[TB] FAIL sat_pos: got %h want 7fffffff", result[0][1]); end
        for (int i = 0; i < D1; i++)
            for (int j = 0; j < D3; j++) begin
                checks++;
                if (result[i][j] !== exp_m[i][j]) begin
                    errors++;
                    $display("[TB] FAIL sat_model[%0d][%0d]: got %h want %h", i, j, result[i][j], exp_m[i][j]);
                end
            end
    endtask

    task automatic test_random();
        mat_t exp_m;
        int lat;
        for (int p = 0; p < 6; p++) begin
            mat_in = rand_mat();
            bias = rand_vec();
            exp_m = ref_matrix(mat_in, bias);
            run_pass(1'b1, lat);
            checks++;
            if (lat !== PASS_LAT) begin errors++; $display("[TB] FAIL rand_latency p%0d: got %0d want %0d", p, lat, PASS_LAT); end
            for (int i = 0; i < D1; i++)
                for (int j = 0; j < D3; j++) begin
                    checks++;
                    if (result[i][j] !== exp_m[i][j]) begin
                        errors++;
                        $display("[TB] FAIL rand_model p%0d [%0d][%0d]: got %h want %h", p, i, j, result[i][j], exp_m[i][j]);
                    end
                end
        end
    endtask

    task automatic test_ignored_edges();
        int done_count;
        int first_done;
        done_count = 0;
        first_done = -1;
        mat_in = rand_mat();
        bias = rand_vec();
        start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            if (i == 2) start = 1'b0;
            if (i == 3) start = 1'b1;
            @(posedge clk); #1;
            if (done) begin
                done_count++;
                if (first_done < 0) first_done = i;
            end
        end
        checks++;
        if (first_done !== PASS_LAT) begin errors++; $display("[TB] FAIL held_first_done: got %0d want %0d", first_done, PASS_LAT); end
        checks++;
        if (done_count !== 1) begin errors++; $display("[TB] FAIL held_done_count: got %0d want 1", done_count); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL held_busy_idle: got %b want 0", busy); end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        mat_t exp_m;
        int lat;
        int done_count;
        mat_in = rand_mat();
        bias = rand_vec();
        start = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done: got %b want 0", done); end
        for (int i = 0; i < D1; i++)
            for (int j = 0; j < D3; j++) begin
                checks++;
                if (result[i][j] !== '0) begin
                    errors++;
                    $display("[TB] FAIL midrst_result[%0d][%0d]: got %h want 0", i, j, result[i][j]);
                end
            end
        rst = 1'b0;
        done_count = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) done_count++;
        end
        checks++;
        if (done_count !== 0) begin errors++; $display("[TB] FAIL midrst_no_done: got %0d want 0", done_count); end
        mat_in = rand_mat();
        bias = rand_vec();
        exp_m = ref_matrix(mat_in, bias);
        run_pass(1'b0, lat);
        checks++;
        if (lat !== PASS_LAT) begin errors++; $display("[TB] FAIL midrst_latency: got %0d want %0d", lat, PASS_LAT); end
        for (int i = 0; i < D1; i++)
            for (int j = 0; j < D3; j++) begin
                checks++;
                if (result[i][j] !== exp_m[i][j]) begin
                    errors++;
                    $display("[TB] FAIL midrst_model[%0d][%0d]: got %h want %h", i, j, result[i][j], exp_m[i][j]);
                end
            end
    endtask

    task automatic test_back_to_back();
        mat_t exp_a;
        mat_t exp_b;
        int lat;
        mat_in = rand_mat();
        bias = rand_vec();
        exp_a = ref_matrix(mat_in, bias);
        run_pass(1'b0, lat);
        do begin
            mat_in = rand_mat();
            bias = rand_vec();
            exp_b = ref_matrix(mat_in, bias);
        end while (exp_b[D1-1][D3-1] === exp_a[D1-1][D3-1]);
        lat = -1;
        start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 3) begin
                checks++;
                if (result[0][0] !== exp_b[0][0]) begin
                    errors++;
                    $display("[TB] FAIL b2b_first_new: got %h want %h", result[0][0], exp_b[0][0]);
                end
                checks++;
                if (result[D1-1][D3-1] !== exp_a[D1-1][D3-1]) begin
                    errors++;
                    $display("[TB] FAIL b2b_last_kept: got %h want %h", result[D1-1][D3-1], exp_a[D1-1][D3-1]);
                end
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (lat !== PASS_LAT) begin errors++; $display("[TB] FAIL b2b_latency: got %0d want %0d", lat, PASS_LAT); end
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < D1; i++)
            for (int j = 0; j < D3; j++) begin
                checks++;
                if (result[i][j] !== exp_b[i][j]) begin
                    errors++;
                    $display("[TB] FAIL b2b_hold[%0d][%0d]: got %h want %h", i, j, result[i][j], exp_b[i][j]);
                end
            end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        mat_in = '0;
        bias = '0;
        test_reset();
        test_relu_basic();
        test_saturation();
        test_random();
        test_ignored_edges();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
